// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the immediate-extension pipeline.
// Holds the Ctrl encodings, the Imm26 field bit positions and a sign-extension helper.
package imm_pkg;

  // Extension modes carried on Ctrl; encodings 5..7 are illegal.
  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_D    = 3'b001,
    IMM_B    = 3'b010,
    IMM_CBZ  = 3'b011,
    IMM_MOVZ = 3'b100
  } imm_ctrl_e;

  // I-type: 12-bit field plus a "shift by 12" flag
  localparam int I_LSB     = 10;
  localparam int I_MSB     = 21;
  localparam int I_SH_BIT  = 22;
  // D-type: 9-bit signed offset
  localparam int D_LSB     = 12;
  localparam int D_MSB     = 20;
  // B-type: the whole 26-bit field is a signed offset
  localparam int B_LSB     = 0;
  localparam int B_MSB     = 25;
  // CBZ: 19-bit signed offset
  localparam int CBZ_LSB   = 5;
  localparam int CBZ_MSB   = 23;
  // MOVZ: 16-bit payload and a 2-bit halfword selector
  localparam int MOVZ_LSB  = 5;
  localparam int MOVZ_MSB  = 20;
  localparam int HW_LSB    = 21;
  localparam int HW_MSB    = 22;

  // Sign-extend the low 'width' bits of 'field' to 64 bits.
  function automatic logic [63:0] sext64(input logic [25:0] field, input int unsigned width);
    logic [63:0] res;
    for (int unsigned i = 0; i < 64; i++) begin
      res[i] = (i < width) ? field[i] : field[width-1];
    end
    return res;
  endfunction

endpackage

// File: rtl/imm_extend_core.sv
// imm_extend_core: combinational immediate extraction/extension.
// Optional feature macro: IMMX_BRSHIFT_EN (B-type and CBZ offsets scaled by 4).
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int DATA_W = 64   // 32 or 64
) (
  input  logic [25:0]       imm26,
  input  logic [2:0]        ctrl,
  output logic [DATA_W-1:0] value,
  output logic              err
);

`ifdef IMMX_BRSHIFT_EN
  localparam int BR_SH = 2;   // word offset -> byte offset
`else
  localparam int BR_SH = 0;
`endif

  logic [63:0] full;

  // Decode the mode and build the 64-bit extended value; truncation happens at the output.
  always_comb begin
    full = '0;
    err  = 1'b0;
    case (ctrl)
      IMM_I: begin
        full = {52'd0, imm26[I_MSB:I_LSB]};
        if (imm26[I_SH_BIT]) begin
          full = full << 12;
        end
      end
      IMM_D:   full = sext64({17'd0, imm26[D_MSB:D_LSB]}, 9);
      IMM_B:   full = sext64(imm26[B_MSB:B_LSB], 26) << BR_SH;
      IMM_CBZ: full = sext64({7'd0, imm26[CBZ_MSB:CBZ_LSB]}, 19) << BR_SH;
      IMM_MOVZ: begin
        // A 32-bit result cannot hold halfwords 2 or 3.
        if ((DATA_W == 32) && imm26[HW_MSB]) begin
          err = 1'b1;
        end else begin
          full = {48'd0, imm26[MOVZ_MSB:MOVZ_LSB]} << {imm26[HW_MSB:HW_LSB], 4'b0000};
        end
      end
      default: err = 1'b1;
    endcase
  end

  assign value = full[DATA_W-1:0];

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage valid/ready pipeline around imm_extend_core.
// S1 registers the raw request, S2 registers the extended result.
// Optional feature macro: IMMX_BRSHIFT_EN (handled inside imm_extend_core).
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W = 64,   // 32 or 64
  parameter int TAG_W  = 4
) (
  input  logic              Clk,
  input  logic              Reset_L,
  input  logic              InValid,
  output logic              InReady,
  input  logic [25:0]       Imm26,
  input  logic [2:0]        Ctrl,
  input  logic [TAG_W-1:0]  TagIn,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] BusImm,
  output logic [TAG_W-1:0]  TagOut,
  output logic              Err
);

  logic              s1_valid_reg;
  logic [25:0]       s1_imm_reg;
  logic [2:0]        s1_ctrl_reg;
  logic [TAG_W-1:0]  s1_tag_reg;

  logic              s2_valid_reg;
  logic [DATA_W-1:0] s2_imm_reg;
  logic [TAG_W-1:0]  s2_tag_reg;
  logic              s2_err_reg;

  logic              s2_load;
  logic              accept;
  logic [DATA_W-1:0] ext_value;
  logic              ext_err;

  // S2 can take a new entry when it is empty or its entry leaves this cycle.
  assign s2_load = !s2_valid_reg || OutReady;
  assign InReady = !Flush && (!s1_valid_reg || s2_load);
  assign accept  = InValid && InReady;

  imm_extend_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .imm26 (s1_imm_reg),
    .ctrl  (s1_ctrl_reg),
    .value (ext_value),
    .err   (ext_err)
  );

  // S1: capture an accepted request, or empty out when the entry moves to S2.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      s1_valid_reg <= 1'b0;
      s1_imm_reg   <= '0;
      s1_ctrl_reg  <= '0;
      s1_tag_reg   <= '0;
    end else if (Flush) begin
      s1_valid_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_imm_reg   <= Imm26;
      s1_ctrl_reg  <= Ctrl;
      s1_tag_reg   <= TagIn;
    end else if (s2_load) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // S2: load the extended result whenever the output slot is free; hold otherwise.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      s2_valid_reg <= 1'b0;
      s2_imm_reg   <= '0;
      s2_tag_reg   <= '0;
      s2_err_reg   <= 1'b0;
    end else if (Flush) begin
      s2_valid_reg <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_imm_reg <= ext_value;
        s2_tag_reg <= s1_tag_reg;
        s2_err_reg <= ext_err;
      end
    end
  end

  assign OutValid = s2_valid_reg;
  assign BusImm   = s2_imm_reg;
  assign TagOut   = s2_tag_reg;
  assign Err      = s2_err_reg;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed and randomized checks of imm_extend_pipe at DATA_W=64 and 32.
module tb_imm_extend_pipe;

  logic        Clk = 1'b0;
  logic        Reset_L;
  logic        InValid;
  logic [25:0] Imm26;
  logic [2:0]  Ctrl;
  logic [3:0]  TagIn;
  logic        Flush;
  logic        OutReady;

  logic        InReady, OutValid, Err;
  logic [63:0] BusImm;
  logic [3:0]  TagOut;
  logic        InReady32, OutValid32, Err32;
  logic [31:0] BusImm32;
  logic [3:0]  TagOut32;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [63:0] v64;
    bit          e64;
    logic [63:0] v32;
    bit          e32;
    logic [3:0]  tag;
    int          edge_no;
  } item_t;

  item_t q[$];

  always #5 Clk = ~Clk;

  imm_extend_pipe #(.DATA_W(64), .TAG_W(4)) dut (
    .Clk(Clk), .Reset_L(Reset_L), .InValid(InValid), .InReady(InReady),
    .Imm26(Imm26), .Ctrl(Ctrl), .TagIn(TagIn), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .BusImm(BusImm),
    .TagOut(TagOut), .Err(Err)
  );

  imm_extend_pipe #(.DATA_W(32), .TAG_W(4)) dut32 (
    .Clk(Clk), .Reset_L(Reset_L), .InValid(InValid), .InReady(InReady32),
    .Imm26(Imm26), .Ctrl(Ctrl), .TagIn(TagIn), .Flush(Flush),
    .OutValid(OutValid32), .OutReady(OutReady), .BusImm(BusImm32),
    .TagOut(TagOut32), .Err(Err32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: arithmetic on the field values taken straight from the mode rules.
  function automatic logic [63:0] model(input logic [25:0] imm, input logic [2:0] ctrl,
                                        input int dw, output bit err);
    longint v;
    longint f;
    longint hw;
    longint scale;
`ifdef IMMX_BRSHIFT_EN
    scale = 4;
`else
    scale = 1;
`endif
    err = 0;
    v   = 0;
    f   = longint'(imm);
    case (ctrl)
      3'd0: begin
        v = (f / 1024) % 4096;
        if (imm[22]) v = v * 4096;
      end
      3'd1: begin
        v = (f / 4096) % 512;
        if (v >= 256) v = v - 512;
      end
      3'd2: begin
        v = f;
        if (v >= 33554432) v = v - 67108864;
        v = v * scale;
      end
      3'd3: begin
        v = (f / 32) % 524288;
        if (v >= 262144) v = v - 524288;
        v = v * scale;
      end
      3'd4: begin
        hw = (f / 2097152) % 4;
        if (dw == 32 && hw >= 2) err = 1;
        else v = ((f / 32) % 65536) << (16 * hw);
      end
      default: err = 1;
    endcase
    if (dw == 32) return {32'h0, v[31:0]};
    return v;
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic cycle(input bit iv, input logic [25:0] imm, input logic [2:0] ctrl,
                       input logic [3:0] tag, input bit ordy, input bit fl);
    bit    exp_ready, exp_ov, acc, dlv;
    item_t it;
    @(negedge Clk);
    InValid = iv; Imm26 = imm; Ctrl = ctrl; TagIn = tag; OutReady = ordy; Flush = fl;
    #1;
    exp_ready = !fl && (q.size() < 2 || ordy);
    exp_ov    = (q.size() > 0) && (edge_cnt >= q[0].edge_no + 1);
    chk("in_ready", 64'(InReady), 64'(exp_ready));
    chk("out_valid", 64'(OutValid), 64'(exp_ov));
    chk("out_valid32", 64'(OutValid32), 64'(exp_ov));
    if (exp_ov) begin
      chk("bus_imm", BusImm, q[0].v64);
      chk("err", 64'(Err), 64'(q[0].e64));
      chk("tag_out", 64'(TagOut), 64'(q[0].tag));
      chk("bus_imm32", 64'(BusImm32), q[0].v32);
      chk("err32", 64'(Err32), 64'(q[0].e32));
      chk("tag_out32", 64'(TagOut32), 64'(q[0].tag));
    end
    acc = iv && exp_ready;
    dlv = exp_ov && ordy;
    @(posedge Clk);
    edge_cnt++;
    if (fl) begin
      q.delete();
    end else begin
      if (dlv) void'(q.pop_front());
      if (acc) begin
        it.v64 = model(imm, ctrl, 64, it.e64);
        it.v32 = model(imm, ctrl, 32, it.e32);
        it.tag = tag;
        it.edge_no = edge_cnt;
        q.push_back(it);
      end
    end
    $display("cyc=%0d iv=%0b ctrl=%0d imm=%h tag=%0d ordy=%0b flush=%0b acc=%0b dlv=%0b",
             edge_cnt, iv, ctrl, imm, tag, ordy, fl, acc, dlv);
  endtask

  // Send one request into an idle pipe and compare the result against fixed values.
  task automatic directed(input string name, input logic [25:0] imm, input logic [2:0] ctrl,
                          input logic [63:0] x64, input bit xe64,
                          input logic [63:0] x32, input bit xe32);
    cycle(1, imm, ctrl, 4'd5, 0, 0);
    cycle(0, '0, '0, '0, 0, 0);
    #1;
    chk({name, "_valid"}, 64'(OutValid), 64'd1);
    chk({name, "_bus64"}, BusImm, x64);
    chk({name, "_err64"}, 64'(Err), 64'(xe64));
    chk({name, "_bus32"}, 64'(BusImm32), x32);
    chk({name, "_err32"}, 64'(Err32), 64'(xe32));
    cycle(0, '0, '0, '0, 1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle(0, '0, '0, '0, 1, 0);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    Reset_L = 1'b0; InValid = 0; Imm26 = '0; Ctrl = '0; TagIn = '0; Flush = 0; OutReady = 0;
    #12;
    chk("rst_out_valid", 64'(OutValid), 64'd0);
    chk("rst_bus_imm", BusImm, 64'd0);
    chk("rst_tag_out", 64'(TagOut), 64'd0);
    chk("rst_err", 64'(Err), 64'd0);
    Reset_L = 1'b1;

    // Mode values, including sign and width boundaries
    directed("i_plain", 26'h03F_FC00, 3'd0, 64'h0000_0000_0000_0FFF, 0, 64'h0000_0FFF, 0);
    directed("i_shift", 26'h07F_FC00, 3'd0, 64'h0000_0000_00FF_F000, 0, 64'h00FF_F000, 0);
    directed("d_neg",   26'h010_0000, 3'd1, 64'hFFFF_FFFF_FFFF_FF00, 0, 64'hFFFF_FF00, 0);
`ifdef IMMX_BRSHIFT_EN
    directed("b_neg",   26'h200_0000, 3'd2, 64'hFFFF_FFFF_F800_0000, 0, 64'hF800_0000, 0);
    directed("cbz_neg", 26'h080_0000, 3'd3, 64'hFFFF_FFFF_FFF0_0000, 0, 64'hFFF0_0000, 0);
`else
    directed("b_neg",   26'h200_0000, 3'd2, 64'hFFFF_FFFF_FE00_0000, 0, 64'hFE00_0000, 0);
    directed("cbz_neg", 26'h080_0000, 3'd3, 64'hFFFF_FFFF_FFFC_0000, 0, 64'hFFFC_0000, 0);
`endif
    directed("movz_hw2", 26'h057_DDE0, 3'd4, 64'h0000_BEEF_0000_0000, 0, 64'h0, 1);
    directed("movz_hw1", 26'h037_DDE0, 3'd4, 64'h0000_0000_BEEF_0000, 0, 64'hBEEF_0000, 0);
    directed("ctrl7",    26'h3FF_FFFF, 3'd7, 64'h0, 1, 64'h0, 1);

    // Backpressure: tags 1,2,3 with OutReady low for 3 cycles
    cycle(1, 26'h123, 3'd0, 4'd1, 0, 0);
    cycle(1, 26'h456, 3'd1, 4'd2, 0, 0);
    cycle(1, 26'h789, 3'd2, 4'd3, 0, 0);
    chk("bp_occupancy", 64'(q.size()), 64'd2);
    cycle(1, 26'h789, 3'd2, 4'd3, 1, 0);
    drain();

    // Flush with both stages full: nothing from them may come out
    cycle(1, 26'h111, 3'd4, 4'd8, 0, 0);
    cycle(1, 26'h222, 3'd3, 4'd9, 0, 0);
    cycle(0, '0, '0, '0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, '0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 26'($urandom()), 3'($urandom_range(0, 7)),
            4'($urandom()), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    drain();

    // Asynchronous reset mid-stream
    cycle(1, 26'h0AB_CDE0, 3'd4, 4'd6, 0, 0);
    cycle(1, 26'h1234, 3'd1, 4'd7, 0, 0);
    cycle(0, '0, '0, '0, 0, 0);
    #2;
    Reset_L = 1'b0;
    #1;
    chk("arst_out_valid", 64'(OutValid), 64'd0);
    chk("arst_bus_imm", BusImm, 64'd0);
    chk("arst_tag_out", 64'(TagOut), 64'd0);
    chk("arst_err", 64'(Err), 64'd0);
    q.delete();
    #1;
    Reset_L = 1'b1;
    cycle(1, 26'h03F_FC00, 3'd0, 4'd4, 1, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
